// File: rtl/gb_dma_pkg.sv
// gb_dma_pkg: shared state encoding, addresses and source remap for the OAM DMA arbiter
package gb_dma_pkg;
  typedef enum logic [1:0] {DmaIdle, DmaStart, DmaTransfer, DmaDrain} dma_state_e;
  localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
  localparam logic [7:0]  HIGH_PAGE    = 8'hFF;
  function automatic logic [7:0] remap(input logic [7:0] s);
    return (s >= 8'hE0) ? s - 8'h20 : s;
  endfunction
endpackage

// File: rtl/oam_dma_arbiter.sv
// oam_dma_arbiter: OAM DMA sequencer and CPU/DMA bus arbiter; define DMA_BUS_CONFLICT_EN to expose the DMA byte on locked-out CPU reads
module oam_dma_arbiter
  import gb_dma_pkg::*;
#(
  parameter int LENGTH      = 160,
  parameter int START_DELAY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  t_cycle,
  input  logic        cpu_mem_enable,
  input  logic        cpu_mem_write,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_data_out,
  output logic [7:0]  cpu_data_in,
  output logic        bus_enable,
  output logic        bus_write,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_data_write,
  input  logic [7:0]  bus_data_read,
  output logic        hi_enable,
  input  logic [7:0]  hi_data_read,
  output logic        oam_enable,
  output logic [7:0]  oam_addr,
  output logic [7:0]  oam_data_write,
  output logic        dma_active
);
  localparam logic [7:0]  LAST     = 8'(LENGTH - 1);
  localparam logic [15:0] LAST_DLY = 16'(START_DELAY - 1);
  dma_state_e  state, state_n;
  logic [7:0]  src, src_n, act_src, act_src_n, idx, idx_n, wr_idx, wr_idx_n, data, data_n;
  logic [15:0] dly, dly_n;
  logic        wr_valid, wr_valid_n, pend, pend_n, hold, hold_n;
  logic        commit, is_reg, is_hi, wr46, xfer, cpu_bus, lock;
  assign commit = t_cycle == 2'd3;
  assign is_reg = cpu_addr == DMA_REG_ADDR;
  assign is_hi  = cpu_addr[15:8] == HIGH_PAGE;
  assign wr46   = cpu_mem_enable & cpu_mem_write & is_reg;
  assign xfer   = state == DmaTransfer;
  always_comb begin
    state_n    = state;
    src_n      = src;
    act_src_n  = act_src;
    idx_n      = idx;
    wr_idx_n   = wr_idx;
    data_n     = data;
    dly_n      = dly;
    wr_valid_n = wr_valid;
    pend_n     = pend;
    hold_n     = hold;
    if (commit) begin
      wr_valid_n = xfer;
      if (xfer) begin
        data_n   = bus_data_read;
        wr_idx_n = idx;
        state_n  = (idx == LAST) ? DmaDrain : DmaTransfer;
        idx_n    = (idx == LAST) ? idx : idx + 8'd1;
      end
      // a restart that outlives the old transfer waits in Start with the lockout held
      if (state == DmaDrain) begin
        state_n = (pend || wr46) ? DmaStart : DmaIdle;
        hold_n  = pend || wr46;
      end
      if (pend) begin
        dly_n = dly + 16'd1;
        if (dly == LAST_DLY && !wr46) begin
          state_n   = DmaTransfer;
          idx_n     = 8'd0;
          act_src_n = remap(src);
          pend_n    = 1'b0;
          hold_n    = 1'b0;
        end
      end
      if (wr46) begin
        src_n   = cpu_data_out;
        pend_n  = 1'b1;
        dly_n   = 16'd0;
        state_n = (state == DmaIdle) ? DmaStart : state_n;
      end
    end
  end
  always_ff @(posedge clk)
    if (reset) begin
      state    <= DmaIdle;
      src      <= 8'hFF;
      act_src  <= 8'h00;
      idx      <= 8'h00;
      wr_idx   <= 8'h00;
      data     <= 8'h00;
      dly      <= 16'd0;
      wr_valid <= 1'b0;
      pend     <= 1'b0;
      hold     <= 1'b0;
    end else begin
      state    <= state_n;
      src      <= src_n;
      act_src  <= act_src_n;
      idx      <= idx_n;
      wr_idx   <= wr_idx_n;
      data     <= data_n;
      dly      <= dly_n;
      wr_valid <= wr_valid_n;
      pend     <= pend_n;
      hold     <= hold_n;
    end
  always_comb begin
    dma_active     = xfer || state == DmaDrain || (state == DmaStart && hold);
    cpu_bus        = cpu_mem_enable & ~is_hi & ~dma_active;
`ifdef DMA_BUS_CONFLICT_EN
    lock           = 1'b0;
`else
    lock           = dma_active;
`endif
    bus_enable     = xfer | cpu_bus;
    bus_write      = ~xfer & cpu_bus & cpu_mem_write;
    bus_addr       = xfer ? {act_src, idx} : cpu_addr;
    bus_data_write = cpu_data_out;
    hi_enable      = cpu_mem_enable & is_hi & ~is_reg;
    oam_enable     = wr_valid;
    oam_addr       = wr_idx;
    oam_data_write = data;
    cpu_data_in    = !cpu_mem_enable ? 8'hFF :
                     is_reg          ? src :
                     is_hi           ? hi_data_read :
                     lock            ? 8'hFF : bus_data_read;
  end
endmodule
